// File: rtl/arc4_pkg.sv
// rtl/arc4_pkg.sv - shared types and constants for the ARC4 key search
// Purpose: key type, printable-ASCII bounds, search FSM state encoding and
//          the byte acceptance test used by the plaintext scanner.
// Ports:   none (package).
package arc4_pkg;

  typedef logic [23:0] key_t;

  localparam logic [7:0] ASCII_MIN = 8'h20;
  localparam logic [7:0] ASCII_MAX = 8'h7E;

  typedef enum logic [3:0] {
    S_IDLE,
    S_START,
    S_WBUSY,
    S_WDONE,
    S_RLEN,
    S_CHK,
    S_NEXT,
    S_FOUND,
    S_FAIL
  } search_state_t;

  function automatic logic is_printable(input logic [7:0] b);
    return (b >= ASCII_MIN) && (b <= ASCII_MAX);
  endfunction

endpackage

// File: rtl/arc4_key_search_pt_checker.sv
// rtl/arc4_key_search_pt_checker.sv - pipelined printable-byte scanner over pt[1..len]
// Purpose: after start, reads pt[1..len] from a 1-cycle-latency memory, one byte
//          per cycle, and reports done/pass on the first failing byte or after
//          byte len passes. Caller guarantees len >= 1 at start.
// Ports:   clk, rst_n       clock, async active-low reset
//          start            1-cycle pulse; len must be valid from the next cycle
//          len[7:0]         message length L
//          pt_addr[7:0]     read address, never exceeds len
//          pt_rddata[7:0]   read data for the address of the previous cycle
//          done, pass       1-cycle verdict strobe; pass qualifies done
module pt_checker
  import arc4_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] len,
  output logic [7:0] pt_addr,
  input  logic [7:0] pt_rddata,
  output logic       done,
  output logic       pass
);

  logic       busy_q;
  logic       vld_q;   // pt_rddata holds a byte of the message this cycle
  logic [7:0] addr_q;
  logic [7:0] idx_q;   // index of the byte currently on pt_rddata

  assign pt_addr = addr_q;

  always_comb begin
    done = 1'b0;
    pass = 1'b0;
    if (busy_q && vld_q) begin
      if (!is_printable(pt_rddata)) begin
        done = 1'b1;
      end else if (idx_q == len) begin
        done = 1'b1;
        pass = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      vld_q  <= 1'b0;
      addr_q <= 8'd0;
      idx_q  <= 8'd0;
    end else if (start) begin
      busy_q <= 1'b1;
      vld_q  <= 1'b0;
      addr_q <= 8'd1;
      idx_q  <= 8'd1;
    end else if (busy_q) begin
      if (done) begin
        busy_q <= 1'b0;
      end else begin
        vld_q <= 1'b1;
        if (vld_q) idx_q <= idx_q + 8'd1;
        // Address runs one ahead of the data but stops at len.
        if (addr_q < len) addr_q <= addr_q + 8'd1;
      end
    end
  end

endmodule

// File: rtl/arc4_key_search.sv
// rtl/arc4_key_search.sv - brute-force key search controller above the arc4 core
// Purpose: steps candidate keys KEY_START, +KEY_STEP, ... up to KEY_MAX, runs the
//          arc4 core on each and accepts the first whose plaintext is all printable.
// Ports:   clk, rst_n            clock, async active-low reset
//          en / rdy              start pulse / idle
//          key_valid, key[23:0]  search result
//          a4_en, a4_rdy         arc4 start pulse / arc4 ready
//          a4_key[23:0]          candidate key to arc4
//          pt_own                pt-memory address port select
//          pt_addr, pt_rddata    pt-memory read port (1-cycle latency)
module arc4_key_search
  import arc4_pkg::*;
#(
  parameter key_t KEY_START = 24'h000000,
  parameter key_t KEY_STEP  = 24'h000001,
  parameter key_t KEY_MAX   = 24'hFFFFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  output logic        rdy,
  output logic        key_valid,
  output logic [23:0] key,
  output logic        a4_en,
  input  logic        a4_rdy,
  output logic [23:0] a4_key,
  output logic        pt_own,
  output logic [7:0]  pt_addr,
  input  logic [7:0]  pt_rddata
);

  search_state_t state_q, state_d;

  key_t       cand_q;
  key_t       a4_key_q;
  key_t       key_q;
  logic       key_valid_q;
  logic       pt_own_q;
  logic [7:0] len_q;
  logic       rlen_phase_q;  // 0: length read in flight, 1: length on pt_rddata
  logic       chk_start;
  logic       chk_done;
  logic       chk_pass;
  logic [7:0] chk_addr;

  // 25-bit sum so a wrap past 24'hFFFFFF is seen as a carry, not a small key.
  logic [24:0] cand_sum;
  logic        step_ok;

  assign cand_sum = {1'b0, cand_q} + {1'b0, KEY_STEP};
  assign step_ok  = !cand_sum[24] && (cand_sum[23:0] <= KEY_MAX);

  assign rdy       = (state_q == S_IDLE);
  assign key_valid = key_valid_q;
  assign key       = key_q;
  assign a4_key    = a4_key_q;
  assign pt_own    = pt_own_q;
  assign pt_addr   = (state_q == S_CHK) ? chk_addr : 8'd0;

  pt_checker u_pt_checker (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (chk_start),
    .len       (len_q),
    .pt_addr   (chk_addr),
    .pt_rddata (pt_rddata),
    .done      (chk_done),
    .pass      (chk_pass)
  );

  always_comb begin
    state_d   = state_q;
    a4_en     = 1'b0;
    chk_start = 1'b0;
    case (state_q)
      S_IDLE:  if (en) state_d = S_START;
      S_START: begin
        if (a4_rdy) begin
          a4_en   = 1'b1;
          state_d = S_WBUSY;
        end
      end
      // The core still shows rdy=1 for two cycles after a4_en; only a low
      // a4_rdy proves the run has begun.
      S_WBUSY: if (!a4_rdy) state_d = S_WDONE;
      S_WDONE: if (a4_rdy) state_d = S_RLEN;
      S_RLEN: begin
        if (rlen_phase_q) begin
          if (pt_rddata == 8'd0) begin
            state_d = S_FOUND;
          end else begin
            chk_start = 1'b1;
            state_d   = S_CHK;
          end
        end
      end
      S_CHK:   if (chk_done) state_d = chk_pass ? S_FOUND : S_NEXT;
      S_NEXT:  state_d = step_ok ? S_START : S_FAIL;
      S_FOUND: state_d = S_IDLE;
      S_FAIL:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cand_q       <= KEY_START;
      a4_key_q     <= KEY_START;
      key_q        <= 24'd0;
      key_valid_q  <= 1'b0;
      pt_own_q     <= 1'b0;
      len_q        <= 8'd0;
      rlen_phase_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pt_own_q     <= (state_d == S_RLEN) || (state_d == S_CHK);
      rlen_phase_q <= (state_q == S_RLEN) && !rlen_phase_q;
      if ((state_q == S_RLEN) && rlen_phase_q) len_q <= pt_rddata;
      case (state_q)
        S_IDLE: begin
          if (en) begin
            key_valid_q <= 1'b0;
            cand_q      <= KEY_START;
            a4_key_q    <= KEY_START;
          end
        end
        S_NEXT: begin
          if (step_ok) begin
            cand_q   <= cand_sum[23:0];
            a4_key_q <= cand_sum[23:0];
          end
        end
        S_FOUND: begin
          key_q       <= cand_q;
          key_valid_q <= 1'b1;
        end
        S_FAIL: begin
          key_q       <= cand_q;
          key_valid_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_arc4_key_search.sv
// tb/tb_arc4_key_search.sv - directed bench for arc4_key_search with arc4 model and pt RAM
module tb_arc4_key_search;

  localparam int RUN = 8;

  logic        clk;
  logic        rst_n;
  logic        en_v        [3];
  logic        rdy_v       [3];
  logic        key_valid_v [3];
  logic [23:0] key_v       [3];
  logic        a4_en_v     [3];
  logic [23:0] a4_key_v    [3];
  logic        pt_own_v    [3];
  logic [7:0]  pt_addr_v   [3];

  int          en_pulses [3];
  int          viol      [3];
  int          own_first [3];
  logic [7:0]  max_addr  [3];
  logic [23:0] first_key [3];

  int mode;
  int total;
  int bad;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] hello(input logic [7:0] i);
    case (i)
      8'd0: return 8'd5;
      8'd1: return 8'h48;
      8'd2: return 8'h45;
      8'd3: return 8'h4C;
      8'd4: return 8'h4C;
      8'd5: return 8'h4F;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] gen_pt(input int m, input logic [23:0] k, input logic [7:0] i);
    case (m)
      0: begin
        if (k == 24'h000018) return hello(i);
        return (i == 8'd0) ? 8'd5 : (i == 8'd3) ? 8'h01 : 8'h41;
      end
      1: begin
        if (k == 24'h000001) return hello(i);
        return (i == 8'd0) ? 8'd5 : (i == 8'd1) ? 8'h07 : 8'h41;
      end
      2: return 8'h00;
      3: return (i == 8'd0) ? 8'd3 : 8'h7F;
      default: begin
        if (k == 24'h000002)
          return (i == 8'd0) ? 8'd3 : (i == 8'd1) ? 8'h20 : (i == 8'd2) ? 8'h7E : 8'h41;
        if (k == 24'h000000)
          return (i == 8'd0) ? 8'd2 : (i == 8'd1) ? 8'h41 : 8'h1F;
        return (i == 8'd0) ? 8'd2 : (i == 8'd1) ? 8'h7F : 8'h41;
      end
    endcase
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_inst
    logic        a4_rdy;
    logic [7:0]  rdata;
    logic [7:0]  mem [256];
    int          cnt;
    logic [23:0] kcap;
    int          own_run;
    logic        prev_en;
    logic        prev_own;
    logic        fell;

    arc4_key_search #(
      .KEY_START((g == 2) ? 24'hFFFFFB : 24'h000000),
      .KEY_STEP ((g == 2) ? 24'h000002 : 24'h000001),
      .KEY_MAX  ((g == 1) ? 24'h000003 : 24'hFFFFFF)
    ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en_v[g]),
      .rdy       (rdy_v[g]),
      .key_valid (key_valid_v[g]),
      .key       (key_v[g]),
      .a4_en     (a4_en_v[g]),
      .a4_rdy    (a4_rdy),
      .a4_key    (a4_key_v[g]),
      .pt_own    (pt_own_v[g]),
      .pt_addr   (pt_addr_v[g]),
      .pt_rddata (rdata)
    );

    always @(posedge clk) rdata <= mem[pt_addr_v[g]];

    // arc4 model: rdy falls two cycles after en, rises RUN cycles after en
    // with the plaintext for the captured key already in memory.
    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        a4_rdy <= 1'b1;
        cnt    <= 0;
        kcap   <= 24'd0;
      end else if (cnt != 0) begin
        if (cnt == RUN) begin
          a4_rdy <= 1'b1;
          cnt    <= 0;
          for (int i = 0; i < 256; i++) mem[i] <= gen_pt(mode, kcap, i[7:0]);
        end else begin
          cnt <= cnt + 1;
          if (cnt == 2) a4_rdy <= 1'b0;
        end
      end else if (a4_en_v[g]) begin
        cnt  <= 1;
        kcap <= a4_key_v[g];
      end
    end

    always @(negedge clk) begin
      if (rst_n) begin
        if (a4_en_v[g]) begin
          if (en_pulses[g] == 0) first_key[g] = a4_key_v[g];
          en_pulses[g]++;
          if (!a4_rdy || prev_en) viol[g]++;
          fell = 1'b0;
        end
        if (!a4_rdy) fell = 1'b1;
        if (pt_own_v[g] && !prev_own && !fell) viol[g]++;
        if (pt_own_v[g]) begin
          own_run++;
          if (own_first[g] < 0 && pt_addr_v[g] > max_addr[g]) max_addr[g] = pt_addr_v[g];
        end else if (prev_own) begin
          if (own_first[g] < 0) own_first[g] = own_run;
          own_run = 0;
        end
        prev_en  = a4_en_v[g];
        prev_own = pt_own_v[g];
      end else begin
        prev_en  = 1'b0;
        prev_own = 1'b0;
        own_run  = 0;
        fell     = 1'b0;
      end
    end
  end

  task automatic clear_mon(input int g);
    en_pulses[g] = 0;
    viol[g]      = 0;
    own_first[g] = -1;
    max_addr[g]  = 8'd0;
    first_key[g] = 24'hFFFFFF;
  endtask

  task automatic run_search(input int g, input int budget);
    bit ok;
    clear_mon(g);
    @(negedge clk);
    en_v[g] = 1'b1;
    @(negedge clk);
    en_v[g] = 1'b0;
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      if (rdy_v[g]) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL search_timeout dut%0d: rdy=%0b after %0d cycles, want 1", g, rdy_v[g], budget);
    end
  endtask

  task automatic test_reset;
    total++; if (rdy_v[0] !== 1'b1) begin bad++; $display("FAIL reset_rdy: got %0b want 1", rdy_v[0]); end
    total++; if (key_valid_v[0] !== 1'b0) begin bad++; $display("FAIL reset_key_valid: got %0b want 0", key_valid_v[0]); end
    total++; if (key_v[0] !== 24'd0) begin bad++; $display("FAIL reset_key: got %h want 000000", key_v[0]); end
    total++; if (a4_en_v[0] !== 1'b0) begin bad++; $display("FAIL reset_a4_en: got %0b want 0", a4_en_v[0]); end
    total++; if (pt_own_v[0] !== 1'b0) begin bad++; $display("FAIL reset_pt_own: got %0b want 0", pt_own_v[0]); end
    total++; if (pt_addr_v[0] !== 8'd0) begin bad++; $display("FAIL reset_pt_addr: got %h want 00", pt_addr_v[0]); end
    total++; if (a4_key_v[0] !== 24'h000000) begin bad++; $display("FAIL reset_a4_key0: got %h want 000000", a4_key_v[0]); end
    total++; if (a4_key_v[2] !== 24'hFFFFFB) begin bad++; $display("FAIL reset_a4_key2: got %h want fffffb", a4_key_v[2]); end
  endtask

  task automatic test_correct_key;
    mode = 0;
    run_search(0, 3000);
    total++; if (en_pulses[0] !== 25) begin bad++; $display("FAIL key_pulses: got %0d want 25", en_pulses[0]); end
    total++; if (key_valid_v[0] !== 1'b1) begin bad++; $display("FAIL key_valid: got %0b want 1", key_valid_v[0]); end
    total++; if (key_v[0] !== 24'h000018) begin bad++; $display("FAIL key_value: got %h want 000018", key_v[0]); end
    total++; if (first_key[0] !== 24'h000000) begin bad++; $display("FAIL key_first_cand: got %h want 000000", first_key[0]); end
  endtask

  task automatic test_early_reject;
    mode = 1;
    run_search(0, 1000);
    total++; if (en_pulses[0] !== 2) begin bad++; $display("FAIL early_pulses: got %0d want 2", en_pulses[0]); end
    total++; if (key_v[0] !== 24'h000001 || key_valid_v[0] !== 1'b1) begin bad++; $display("FAIL early_key: got %h/%0b want 000001/1", key_v[0], key_valid_v[0]); end
    total++; if (max_addr[0] !== 8'd2) begin bad++; $display("FAIL early_max_addr: got %0d want 2", max_addr[0]); end
    total++; if (own_first[0] !== 4) begin bad++; $display("FAIL early_own_cycles: got %0d want 4", own_first[0]); end
  endtask

  task automatic test_empty_msg;
    mode = 2;
    run_search(0, 1000);
    total++; if (en_pulses[0] !== 1) begin bad++; $display("FAIL empty_pulses: got %0d want 1", en_pulses[0]); end
    total++; if (key_v[0] !== 24'h000000 || key_valid_v[0] !== 1'b1) begin bad++; $display("FAIL empty_key: got %h/%0b want 000000/1", key_v[0], key_valid_v[0]); end
    total++; if (max_addr[0] !== 8'd0) begin bad++; $display("FAIL empty_max_addr: got %0d want 0", max_addr[0]); end
    total++; if (own_first[0] !== 2) begin bad++; $display("FAIL empty_own_cycles: got %0d want 2", own_first[0]); end
  endtask

  task automatic test_boundary;
    mode = 4;
    run_search(0, 1000);
    total++; if (en_pulses[0] !== 3) begin bad++; $display("FAIL bound_pulses: got %0d want 3", en_pulses[0]); end
    total++; if (key_v[0] !== 24'h000002 || key_valid_v[0] !== 1'b1) begin bad++; $display("FAIL bound_key: got %h/%0b want 000002/1", key_v[0], key_valid_v[0]); end
  endtask

  task automatic test_exhaustion;
    mode = 3;
    run_search(1, 1000);
    total++; if (en_pulses[1] !== 4) begin bad++; $display("FAIL exh_pulses: got %0d want 4", en_pulses[1]); end
    total++; if (key_valid_v[1] !== 1'b0) begin bad++; $display("FAIL exh_key_valid: got %0b want 0", key_valid_v[1]); end
    total++; if (key_v[1] !== 24'h000003) begin bad++; $display("FAIL exh_key: got %h want 000003", key_v[1]); end
    run_search(2, 1000);
    total++; if (en_pulses[2] !== 3) begin bad++; $display("FAIL carry_pulses: got %0d want 3", en_pulses[2]); end
    total++; if (key_valid_v[2] !== 1'b0) begin bad++; $display("FAIL carry_key_valid: got %0b want 0", key_valid_v[2]); end
    total++; if (key_v[2] !== 24'hFFFFFF) begin bad++; $display("FAIL carry_key: got %h want ffffff", key_v[2]); end
  endtask

  task automatic test_handshake;
    bit ok;
    mode = 1;
    clear_mon(0);
    @(negedge clk);
    en_v[0] = 1'b1;
    ok = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      if (rdy_v[0]) begin
        ok = 1'b1;
        break;
      end
    end
    en_v[0] = 1'b0;
    repeat (4) @(negedge clk);
    total++; if (!ok) begin bad++; $display("FAIL hs_timeout: rdy=%0b want 1", rdy_v[0]); end
    total++; if (en_pulses[0] !== 2) begin bad++; $display("FAIL hs_pulses: got %0d want 2", en_pulses[0]); end
    total++; if (rdy_v[0] !== 1'b1) begin bad++; $display("FAIL hs_idle: got rdy=%0b want 1", rdy_v[0]); end
    total++; if (key_v[0] !== 24'h000001 || key_valid_v[0] !== 1'b1) begin bad++; $display("FAIL hs_key: got %h/%0b want 000001/1", key_v[0], key_valid_v[0]); end
    total++; if (viol[0] !== 0) begin bad++; $display("FAIL hs_protocol: got %0d violations want 0", viol[0]); end
  endtask

  task automatic test_reset_mid_chk;
    bit ok;
    mode = 0;
    clear_mon(0);
    @(negedge clk);
    en_v[0] = 1'b1;
    @(negedge clk);
    en_v[0] = 1'b0;
    ok = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      if (en_pulses[0] >= 3 && pt_own_v[0]) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    total++; if (!ok) begin bad++; $display("FAIL rst_reach_chk: pt_own=%0b want 1", pt_own_v[0]); end
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++; if (rdy_v[0] !== 1'b1) begin bad++; $display("FAIL rst_rdy: got %0b want 1", rdy_v[0]); end
    total++; if (key_valid_v[0] !== 1'b0) begin bad++; $display("FAIL rst_key_valid: got %0b want 0", key_valid_v[0]); end
    total++; if (key_v[0] !== 24'd0) begin bad++; $display("FAIL rst_key: got %h want 000000", key_v[0]); end
    total++; if (a4_key_v[0] !== 24'd0) begin bad++; $display("FAIL rst_a4_key: got %h want 000000", a4_key_v[0]); end
    total++; if (pt_own_v[0] !== 1'b0) begin bad++; $display("FAIL rst_pt_own: got %0b want 0", pt_own_v[0]); end
    total++; if (pt_addr_v[0] !== 8'd0) begin bad++; $display("FAIL rst_pt_addr: got %h want 00", pt_addr_v[0]); end
    total++; if (a4_en_v[0] !== 1'b0) begin bad++; $display("FAIL rst_a4_en: got %0b want 0", a4_en_v[0]); end
    @(negedge clk);
    rst_n = 1'b1;
    run_search(0, 3000);
    total++; if (first_key[0] !== 24'h000000) begin bad++; $display("FAIL rst_restart_cand: got %h want 000000", first_key[0]); end
    total++; if (key_v[0] !== 24'h000018 || key_valid_v[0] !== 1'b1) begin bad++; $display("FAIL rst_restart_key: got %h/%0b want 000018/1", key_v[0], key_valid_v[0]); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    mode  = 0;
    rst_n = 1'b0;
    for (int g = 0; g < 3; g++) begin
      en_v[g] = 1'b0;
      clear_mon(g);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_reset;
    test_correct_key;
    test_early_reject;
    test_empty_msg;
    test_boundary;
    test_exhaustion;
    test_handshake;
    test_reset_mid_chk;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
